bsg_dmc_ui_arbiter: RTL

Two-requester arbiter and sequencer for the `bsg_dmc` application (Xilinx-style UI) port. It shares a single DMC command/write-data/read-data interface between two requesters, for example the trace-replay engine and the external user port. It grants commands round-robin and locks the write-data channel to the winning writer for the whole burst. It routes in-order read returns back to the issuing requester through a tag FIFO. It sits in the `ui_clk` domain, between the requesters and `bsg_dmc`.

---
 rtl/bsg_dmc_ui_arbiter_if.sv | 74 +++++++
 rtl/bsg_dmc_ui_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bsg_dmc_ui_arbiter_if.sv
// rtl/bsg_dmc_ui_arbiter_if.sv - requester-side and DMC-side UI port bundles for the arbiter
interface bsg_dmc_ui_req_if #(
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 32
);
    localparam int mask_width_lp = ui_data_width_p >> 3;

    logic [1:0][ui_addr_width_p-1:0] req_app_addr_i;
    logic [1:0][2:0]                 req_app_cmd_i;
    logic [1:0]                      req_app_en_i;
    logic [1:0]                      req_app_rdy_o;

    logic [1:0]                      req_app_wdf_wren_i;
    logic [1:0][ui_data_width_p-1:0] req_app_wdf_data_i;
    logic [1:0][mask_width_lp-1:0]   req_app_wdf_mask_i;
    logic [1:0]                      req_app_wdf_end_i;
    logic [1:0]                      req_app_wdf_rdy_o;

    logic [1:0]                      req_app_rd_data_valid_o;
    logic [1:0][ui_data_width_p-1:0] req_app_rd_data_o;
    logic [1:0]                      req_app_rd_data_end_o;

    modport slave (
        input  req_app_addr_i, req_app_cmd_i, req_app_en_i,
        input  req_app_wdf_wren_i, req_app_wdf_data_i, req_app_wdf_mask_i, req_app_wdf_end_i,
        output req_app_rdy_o, req_app_wdf_rdy_o,
        output req_app_rd_data_valid_o, req_app_rd_data_o, req_app_rd_data_end_o
    );

    modport master (
        output req_app_addr_i, req_app_cmd_i, req_app_en_i,
        output req_app_wdf_wren_i, req_app_wdf_data_i, req_app_wdf_mask_i, req_app_wdf_end_i,
        input  req_app_rdy_o, req_app_wdf_rdy_o,
        input  req_app_rd_data_valid_o, req_app_rd_data_o, req_app_rd_data_end_o
    );
endinterface

interface bsg_dmc_ui_app_if #(
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 32
);
    localparam int mask_width_lp = ui_data_width_p >> 3;

    logic [ui_addr_width_p-1:0] app_addr_o;
    logic [2:0]                 app_cmd_o;
    logic                       app_en_o;
    logic                       app_rdy_i;

    logic                       app_wdf_wren_o;
    logic [ui_data_width_p-1:0] app_wdf_data_o;
    logic [mask_width_lp-1:0]   app_wdf_mask_o;
    logic                       app_wdf_end_o;
    logic                       app_wdf_rdy_i;

    logic                       app_rd_data_valid_i;
    logic [ui_data_width_p-1:0] app_rd_data_i;
    logic                       app_rd_data_end_i;

    modport master (
        output app_addr_o, app_cmd_o, app_en_o,
        input  app_rdy_i,
        output app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
        input  app_wdf_rdy_i,
        input  app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
    );

    modport slave (
        input  app_addr_o, app_cmd_o, app_en_o,
        output app_rdy_i,
        input  app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
        output app_wdf_rdy_i,
        output app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i
    );
endinterface

// File: rtl/bsg_dmc_ui_arbiter.sv
// rtl/bsg_dmc_ui_arbiter.sv - round-robin command arbiter with write-burst lock and read tag routing
module bsg_dmc_ui_arbiter #(
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 32,
    parameter int ui_burst_len_p  = 2,
    parameter int rd_tag_depth_p  = 8,
    localparam int mask_width_lp  = ui_data_width_p >> 3,
    localparam int cnt_width_lp   = $clog2(rd_tag_depth_p + 1),
    localparam int ptr_width_lp   = $clog2(rd_tag_depth_p),
    localparam int beat_width_lp  = $clog2(ui_burst_len_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bsg_dmc_ui_req_if.slave         req,
    bsg_dmc_ui_app_if.master        app,
    output logic [cnt_width_lp-1:0] rd_outstanding_o,
    output logic                    error_o
);
    localparam logic [2:0] cmd_write_lp = 3'b000;
    localparam logic [2:0] cmd_read_lp  = 3'b001;

    typedef enum logic [1:0] {IDLE, LOCK, WDATA} state_e;

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_q, last_d;
    logic [beat_width_lp-1:0]  beat_q, beat_d;
    logic [rd_tag_depth_p-1:0] tag_mem_q, tag_mem_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [cnt_width_lp-1:0]   count_q, count_d;
    logic                      error_q, error_d;

    logic pref, grant, blk, cmd_phase, wdf_phase, accept, push, pop;
    logic is_read, is_write, fifo_full, fifo_empty, head, beat_fire, last_beat;

    logic [ui_addr_width_p-1:0] cmd_addr;
    logic [ui_data_width_p-1:0] wdf_data;
    logic [mask_width_lp-1:0]   wdf_mask;

    assign fifo_full  = (count_q == cnt_width_lp'(rd_tag_depth_p));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // LOCK pins the grant to the stalled owner so its command cannot be pre-empted.
    always_comb begin
        pref = ~last_q;
        if (state_q == LOCK)                 grant = owner_q;
        else if (req.req_app_en_i[pref])     grant = pref;
        else if (req.req_app_en_i[~pref])    grant = ~pref;
        else                                 grant = pref;
    end

    assign is_read   = (req.req_app_cmd_i[grant] == cmd_read_lp);
    assign is_write  = (req.req_app_cmd_i[grant] == cmd_write_lp);
    assign blk       = fifo_full & is_read;
    assign cmd_phase = reset_n_i & (state_q != WDATA);
    assign wdf_phase = reset_n_i & (state_q == WDATA);

    assign cmd_addr = req.req_app_addr_i[grant];
    assign wdf_data = req.req_app_wdf_data_i[owner_q];
    assign wdf_mask = req.req_app_wdf_mask_i[owner_q];

    always_comb begin
        app.app_addr_o     = cmd_addr;
        app.app_cmd_o      = req.req_app_cmd_i[grant];
        app.app_en_o       = cmd_phase & req.req_app_en_i[grant] & ~blk;
        req.req_app_rdy_o  = '0;
        if (cmd_phase) req.req_app_rdy_o[grant] = app.app_rdy_i & ~blk;

        app.app_wdf_wren_o    = wdf_phase & req.req_app_wdf_wren_i[owner_q];
        app.app_wdf_data_o    = wdf_data;
        app.app_wdf_mask_o    = wdf_mask;
        app.app_wdf_end_o     = req.req_app_wdf_end_i[owner_q];
        req.req_app_wdf_rdy_o = '0;
        if (wdf_phase) req.req_app_wdf_rdy_o[owner_q] = app.app_wdf_rdy_i;

        // Read data is broadcast; only valid/end are steered by the tag at the FIFO head.
        req.req_app_rd_data_o[0]     = app.app_rd_data_i;
        req.req_app_rd_data_o[1]     = app.app_rd_data_i;
        req.req_app_rd_data_valid_o  = '0;
        req.req_app_rd_data_end_o    = '0;
        if (reset_n_i && !fifo_empty) begin
            req.req_app_rd_data_valid_o[head] = app.app_rd_data_valid_i;
            req.req_app_rd_data_end_o[head]   = app.app_rd_data_end_i;
        end
    end

    assign accept    = app.app_en_o & app.app_rdy_i;
    assign push      = accept & is_read;
    assign pop       = app.app_rd_data_valid_i & app.app_rd_data_end_i & ~fifo_empty;
    assign beat_fire = app.app_wdf_wren_o & app.app_wdf_rdy_i;
    assign last_beat = (beat_q == beat_width_lp'(ui_burst_len_p - 1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE, LOCK: begin
                if (state_q == LOCK && !req.req_app_en_i[owner_q]) begin
                    state_d = IDLE;
                end else if (accept) begin
                    last_d = grant;
                    if (is_write) begin
                        owner_d = grant;
                        beat_d  = '0;
                        state_d = WDATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (app.app_en_o || blk) begin
                    owner_d = grant;
                    state_d = LOCK;
                end
            end
            WDATA: begin
                if (beat_fire) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == ptr_width_lp'(rd_tag_depth_p - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_width_lp'(rd_tag_depth_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
        error_d = error_q | (app.app_rd_data_valid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            beat_q    <= '0;
            tag_mem_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            tag_mem_q <= tag_mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end

    assign rd_outstanding_o = count_q;
    assign error_o          = error_q;
endmodule
